// File: rtl/uart_rx_cfg.sv
// ----------------------------------------------------------------------------
// uart_rx_cfg
//   Configurable UART receiver. The asynchronous rx line is synchronised,
//   each bit is sampled three times around mid-bit and resolved by majority
//   vote. A start bit that does not hold low at mid-bit is rejected as a
//   glitch. Each finished frame reports parity, framing and break status
//   together with the received word.
//
//   Handshake: rx_done_tick is a single-cycle valid strobe with no ready.
//   dout and all flags change only on the cycle rx_done_tick is high and hold
//   their values until the next rx_done_tick or reset. A downstream FIFO must
//   capture on that cycle.
//
// Parameters
//   DBIT     data bits per frame (5..9)
//   PARITY   0 none, 1 even, 2 odd
//   OVS      s_tick ticks per bit (even, >= 8)
//   SB_TICK  ticks spent in the stop state
//
// Ports
//   clk           system clock
//   reset         synchronous active-high reset
//   rx            asynchronous serial input, idle high
//   s_tick        oversampling strobe, one clk wide
//   rx_done_tick  one-clk pulse: frame complete, dout and flags valid
//   dout          received word, first received bit in the LSB
//   parity_err    parity mismatch on the last frame
//   frame_err     stop bit sampled low on the last frame
//   break_det     last frame was a break (every bit low)
//   busy          high whenever the FSM is not idle
//   dbg_state     current FSM state encoding, for debug and checkers
// ----------------------------------------------------------------------------
module uart_rx_cfg #(
    parameter int DBIT    = 8,
    parameter int PARITY  = 0,
    parameter int OVS     = 16,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            parity_err,
    output logic            frame_err,
    output logic            break_det,
    output logic            busy,
    output logic [2:0]      dbg_state
);

    localparam int MAXT = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int SW   = $clog2(MAXT);
    localparam int NW   = $clog2(DBIT);

    localparam logic [SW-1:0] S_MID_LO   = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] S_MID      = SW'(OVS / 2);
    localparam logic [SW-1:0] S_MID_HI   = SW'(OVS / 2 + 1);
    localparam logic [SW-1:0] S_BIT_END  = SW'(OVS - 1);
    localparam logic [SW-1:0] S_STOP_END = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST     = NW'(DBIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4,
        BRK   = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              r_rx_meta;
    logic              r_rx_s;
    logic [SW-1:0]     r_s;
    logic [NW-1:0]     r_n;
    logic [2:0]        r_smp;
    logic [DBIT-1:0]   r_sh;
    logic              r_par;
    logic [DBIT-1:0]   r_dout;
    logic              r_perr;
    logic              r_ferr;
    logic              r_brk;
    logic              r_done;

    logic              w_maj_now;
    logic              w_maj;
    logic              w_xor;
    logic              w_perr;
    logic              w_brk;
    logic              w_framing;
    logic              w_s_clr;
    logic              w_shift;
    logic              w_par_latch;
    logic              w_done_evt;
    logic              w_sampling;

    // Majority at the third sample point uses the live synchronised value,
    // since that sample is being stored on this very cycle.
    assign w_maj_now = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_rx_s) | (r_smp[1] & r_rx_s);
    assign w_maj     = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_smp[2]) | (r_smp[1] & r_smp[2]);

    assign w_xor  = (^r_sh) ^ r_par;
    assign w_perr = (PARITY == 1) ? w_xor : ((PARITY == 2) ? ~w_xor : 1'b0);
    // At the end of the stop state r_smp still holds the three mid-stop-bit
    // samples, so w_maj is the stop bit value.
    assign w_brk  = ~w_maj & (r_sh == '0) & ((PARITY == 0) | ~r_par);

    // Bit-sized states wrap the tick counter every OVS ticks, the stop state
    // runs for SB_TICK ticks which may span more than one bit time.
    assign w_framing = (r_state == START) || (r_state == DATA) || (r_state == PAR);
    assign w_s_clr   = w_framing ? (r_s == S_BIT_END) : (r_s == S_STOP_END);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (!r_rx_s) begin
                    w_next = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (r_s == S_MID_HI && w_maj_now) begin
                        w_next = IDLE;
                    end else if (r_s == S_BIT_END) begin
                        w_next = DATA;
                    end
                end
            end
            DATA: begin
                if (s_tick && r_s == S_BIT_END && r_n == N_LAST) begin
                    w_next = (PARITY != 0) ? PAR : STOP;
                end
            end
            PAR: begin
                if (s_tick && r_s == S_BIT_END) begin
                    w_next = STOP;
                end
            end
            STOP: begin
                if (s_tick && r_s == S_STOP_END) begin
                    w_next = w_brk ? BRK : IDLE;
                end
            end
            BRK: begin
                if (r_rx_s) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        busy        = (r_state != IDLE);
        dbg_state   = r_state;
        w_sampling  = s_tick && (r_state != IDLE) && (r_state != BRK);
        w_shift     = (r_state == DATA) && s_tick && (r_s == S_BIT_END);
        w_par_latch = (r_state == PAR) && s_tick && (r_s == S_BIT_END);
        w_done_evt  = (r_state == STOP) && s_tick && (r_s == S_STOP_END);
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_s       <= '0;
            r_n       <= '0;
            r_smp     <= '0;
            r_sh      <= '0;
            r_par     <= 1'b0;
            r_dout    <= '0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_brk     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_done    <= w_done_evt;

            if (r_state == IDLE || r_state == BRK) begin
                r_s <= '0;
            end else if (s_tick) begin
                r_s <= w_s_clr ? '0 : r_s + SW'(1);
            end

            if (r_state == START) begin
                r_n <= '0;
            end else if (w_shift) begin
                r_n <= r_n + NW'(1);
            end

            if (w_sampling) begin
                if (r_s == S_MID_LO) r_smp[0] <= r_rx_s;
                if (r_s == S_MID)    r_smp[1] <= r_rx_s;
                if (r_s == S_MID_HI) r_smp[2] <= r_rx_s;
            end

            // Shift in at the top so the first bit received ends in the LSB.
            if (w_shift) begin
                r_sh <= {w_maj, r_sh[DBIT-1:1]};
            end

            if (w_par_latch) begin
                r_par <= w_maj;
            end

            if (w_done_evt) begin
                r_dout <= r_sh;
                r_perr <= w_perr;
                r_ferr <= ~w_maj;
                r_brk  <= w_brk;
            end
        end
    end

    assign rx_done_tick = r_done;
    assign dout         = r_dout;
    assign parity_err   = r_perr;
    assign frame_err    = r_ferr;
    assign break_det    = r_brk;

endmodule

// File: tb/tb_uart_rx_cfg.sv
module tb_uart_rx_cfg;

    localparam int OVS  = 16;
    localparam int SB   = 16;
    localparam int TDIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_tick = 1'b0;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    int         tick_cnt = 0;

    logic       done_a, perr_a, ferr_a, brk_a, busy_a;
    logic [7:0] dout_a;
    logic [2:0] st_a;
    logic       done_b, perr_b, ferr_b, brk_b, busy_b;
    logic [6:0] dout_b;
    logic [2:0] st_b;

    int n_checks = 0;
    int n_pass   = 0;
    int pulses_a = 0;
    int pulses_b = 0;

    logic [10:0] exp_a[$];
    logic [9:0]  exp_b[$];

    // clock / tick generation
    always #5 clk = ~clk;

    always @(negedge clk) begin
        tick_cnt = (tick_cnt + 1) % TDIV;
        s_tick   = (tick_cnt == 0);
    end

    uart_rx_cfg #(.DBIT(8), .PARITY(0), .OVS(OVS), .SB_TICK(SB)) u_dut_a (
        .clk(clk), .reset(reset), .rx(rx_a), .s_tick(s_tick),
        .rx_done_tick(done_a), .dout(dout_a), .parity_err(perr_a),
        .frame_err(ferr_a), .break_det(brk_a), .busy(busy_a), .dbg_state(st_a)
    );

    uart_rx_cfg #(.DBIT(7), .PARITY(1), .OVS(OVS), .SB_TICK(SB)) u_dut_b (
        .clk(clk), .reset(reset), .rx(rx_b), .s_tick(s_tick),
        .rx_done_tick(done_b), .dout(dout_b), .parity_err(perr_b),
        .frame_err(ferr_b), .break_det(brk_b), .busy(busy_b), .dbg_state(st_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // reference model: {break, frame_err, parity_err, data}
    function automatic logic [31:0] model(input int dbit, input int parity, input logic [8:0] data,
                                          input logic pbit, input logic stop);
        logic [31:0] d;
        int          ones;
        logic        perr, ferr, brk;
        d    = 32'(data) & ((32'd1 << dbit) - 32'd1);
        ones = $countones(d) + int'(pbit);
        if (parity == 0)      perr = 1'b0;
        else if (parity == 1) perr = (ones % 2) == 1;
        else                  perr = (ones % 2) == 0;
        ferr = !stop;
        brk  = !stop && (d == 0) && (parity == 0 || !pbit);
        return d | (32'(perr) << dbit) | (32'(ferr) << (dbit + 1)) | (32'(brk) << (dbit + 2));
    endfunction

    // scoreboard
    always @(negedge clk) begin
        if (done_a) begin
            pulses_a++;
            if (exp_a.size() == 0) check("unexpected_pulse_a", 32'd1, 32'd0);
            else check("frame_a", 32'({brk_a, ferr_a, perr_a, dout_a}), 32'(exp_a.pop_front()));
        end
        if (done_b) begin
            pulses_b++;
            if (exp_b.size() == 0) check("unexpected_pulse_b", 32'd1, 32'd0);
            else check("frame_b", 32'({brk_b, ferr_b, perr_b, dout_b}), 32'(exp_b.pop_front()));
        end
    end

    // driver tasks
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!s_tick) @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic drive(input int which, input logic v);
        if (which == 0) rx_a = v;
        else            rx_b = v;
    endtask

    task automatic idle(input int which, input int n);
        drive(which, 1'b1);
        wait_ticks(n);
    endtask

    task automatic send_frame(input int which, input int dbit, input int parity, input logic [8:0] data,
                              input logic pbit, input logic stop, input int glitch_idx);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < dbit; i++) bits.push_back(data[i]);
        if (parity != 0) bits.push_back(pbit);
        for (int i = 0; i < bits.size(); i++) begin
            drive(which, bits[i]);
            if (i == glitch_idx) begin
                wait_ticks(OVS / 2);
                drive(which, !bits[i]);
                wait_ticks(1);
                drive(which, bits[i]);
                wait_ticks(OVS / 2 - 1);
            end else begin
                wait_ticks(OVS);
            end
        end
        drive(which, stop);
        wait_ticks(SB);
    endtask

    task automatic push_a(input logic [8:0] data, input logic stop);
        logic [31:0] m;
        m = model(8, 0, data, 1'b0, stop);
        exp_a.push_back(m[10:0]);
    endtask

    task automatic push_b(input logic [8:0] data, input logic pbit, input logic stop);
        logic [31:0] m;
        m = model(7, 1, data, pbit, stop);
        exp_b.push_back(m[9:0]);
    endtask

    task automatic rand_a(input int n);
        logic [8:0] d;
        logic       stop;
        for (int i = 0; i < n; i++) begin
            d    = ($urandom_range(0, 5) == 0) ? 9'd0 : 9'($urandom_range(0, 255));
            stop = ($urandom_range(0, 5) != 0);
            push_a(d, stop);
            send_frame(0, 8, 0, d, 1'b0, stop, -1);
            idle(0, stop ? $urandom_range(0, 6) : OVS + $urandom_range(0, 6));
        end
    endtask

    task automatic rand_b(input int n);
        logic [8:0] d;
        logic       p, stop;
        for (int i = 0; i < n; i++) begin
            d    = ($urandom_range(0, 5) == 0) ? 9'd0 : 9'($urandom_range(0, 127));
            p    = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 5) != 0);
            push_b(d, p, stop);
            send_frame(1, 7, 1, d, p, stop, -1);
            idle(1, stop ? $urandom_range(0, 6) : OVS + $urandom_range(0, 6));
        end
    endtask

    initial begin
        int p0, pb0, k;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dout_a", 32'(dout_a), 32'd0);
        check("rst_flags_a", 32'({done_a, perr_a, ferr_a, brk_a, busy_a}), 32'd0);
        check("rst_state_a", 32'(st_a), 32'd0);
        check("rst_b", 32'({dout_b, done_b, perr_b, ferr_b, brk_b, busy_b}), 32'd0);
        reset = 1'b0;
        idle(0, 4);

        // back-to-back 8N1 frames
        p0 = pulses_a;
        push_a(9'h55, 1'b1);
        push_a(9'hA3, 1'b1);
        send_frame(0, 8, 0, 9'h55, 1'b0, 1'b1, -1);
        send_frame(0, 8, 0, 9'hA3, 1'b0, 1'b1, -1);
        idle(0, 2 * OVS);
        check("b2b_pulses", 32'(pulses_a - p0), 32'd2);

        // 7E1 correct and wrong parity
        pb0 = pulses_b;
        push_b(9'h41, 1'b0, 1'b1);
        send_frame(1, 7, 1, 9'h41, 1'b0, 1'b1, -1);
        idle(1, OVS);
        push_b(9'h41, 1'b1, 1'b1);
        send_frame(1, 7, 1, 9'h41, 1'b1, 1'b1, -1);
        idle(1, 2 * OVS);
        check("par_pulses", 32'(pulses_b - pb0), 32'd2);

        // short glitch is rejected as a false start
        p0 = pulses_a;
        drive(0, 1'b0);
        wait_ticks(4);
        check("glitch_busy", 32'(busy_a), 32'd1);
        drive(0, 1'b1);
        k = 0;
        while (busy_a && k < OVS) begin
            wait_ticks(1);
            k++;
        end
        check("glitch_idle", 32'(busy_a), 32'd0);
        idle(0, OVS);
        check("glitch_pulses", 32'(pulses_a - p0), 32'd0);

        // single-tick flip at mid sample of data bit 3 is voted out
        push_a(9'h0F, 1'b1);
        send_frame(0, 8, 0, 9'h0F, 1'b0, 1'b1, 4);
        idle(0, 2 * OVS);

        // break: 12 bit times low
        p0 = pulses_a;
        push_a(9'h00, 1'b0);
        drive(0, 1'b0);
        wait_ticks(12 * OVS);
        check("brk_hold_busy", 32'(busy_a), 32'd1);
        check("brk_pulses", 32'(pulses_a - p0), 32'd1);
        drive(0, 1'b1);
        wait_ticks(4);
        check("brk_release", 32'(busy_a), 32'd0);
        idle(0, 2 * OVS);
        check("brk_no_second", 32'(pulses_a - p0), 32'd1);

        // stop bit low on non-zero data
        push_a(9'h81, 1'b0);
        send_frame(0, 8, 0, 9'h81, 1'b0, 1'b0, -1);
        idle(0, 2 * OVS);

        // reset during data bit 4
        p0 = pulses_a;
        fork
            send_frame(0, 8, 0, 9'hF0, 1'b0, 1'b1, -1);
            begin
                wait_ticks(5 * OVS + OVS / 2);
                reset = 1'b1;
                @(negedge clk);
                check("midrst_dout", 32'(dout_a), 32'd0);
                check("midrst_flags", 32'({done_a, perr_a, ferr_a, brk_a, busy_a}), 32'd0);
                check("midrst_b", 32'({dout_b, perr_b, ferr_b, brk_b, busy_b}), 32'd0);
                reset = 1'b0;
            end
        join
        idle(0, 2 * OVS);
        check("midrst_no_pulse", 32'(pulses_a - p0), 32'd0);
        push_a(9'h3C, 1'b1);
        send_frame(0, 8, 0, 9'h3C, 1'b0, 1'b1, -1);
        idle(0, 2 * OVS);
        check("after_rst_pulse", 32'(pulses_a - p0), 32'd1);

        // randomized traffic on both receivers
        fork
            rand_a(20);
            rand_b(20);
        join
        k = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && k < 200) begin
            wait_ticks(1);
            k++;
        end
        check("drain_a", 32'(exp_a.size()), 32'd0);
        check("drain_b", 32'(exp_b.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
